sa2x2_ctrl: RTL and testbench
=============================

SA2X2_CTRL -- requirements
Module: sa2x2_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous and active-low.
REQ-003 SHALL have ports: start  in  1  begin job; busy  out  1  job in progress; done  out  1  one-cycle end-of-job pulse.
REQ-004 SHALL have ports: w00, w01, w10, w11  in  8 each  weight matrix W[k][j], sampled on accepted start.
REQ-005 SHALL have ports: act_valid  in  1; act_ready  out  1; act_a0, act_a1  in  8 each  activation vector; act_last  in  1  final vector of job.
REQ-006 SHALL have ports: res_valid  out  1; res_y0, res_y1  out  8 each  result vector; res_last  out  1  result of final vector. No backpressure.
REQ-007 SHALL have array-side ports: sa_clear, sa_weight_load  out  1; sa_w_in1, sa_w_in2, sa_act_in1, sa_act_in2, sa_psum_in1, sa_psum_in2  out  8; sa_psum_out1, sa_psum_out2  in  8.

Function
REQ-008 SHALL compute per vector y_j = a0*W[0][j] + a1*W[1][j], j=0,1, modulo 256 (8-bit wrap, no saturation), using the attached 2x2 weight-stationary array.
REQ-009 SHALL implement FSM IDLE -> CLEAR -> LOAD0 -> LOAD1 -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-010 IDLE: busy=0; start=1 latches W and moves to CLEAR; start ignored in any other state.
REQ-011 CLEAR: sa_clear=1 for exactly one cycle.
REQ-012 LOAD0: sa_weight_load=1, sa_w_in1=W[1][0], sa_w_in2=W[1][1] (bottom row first).
REQ-013 LOAD1: sa_weight_load=1, sa_w_in1=W[0][0], sa_w_in2=W[0][1]; sa_weight_load=0 in all other states.
REQ-014 STREAM: act_ready=1; vector accepted on act_valid&act_ready; act_ready=0 in every other state.
REQ-015 Skew: for a vector accepted at edge T, sa_act_in1=a0 during cycle T+1 and sa_act_in2=a1 during cycle T+2; bubble slots drive 0.
REQ-016 sa_psum_in1 and sa_psum_in2 SHALL be 0 at all times.
REQ-017 Deskew: sa_psum_out1 sampled at cycle T+3, sa_psum_out2 at T+4; res_valid=1 with both values in cycle T+5; fixed latency 5, independent of bubbles.
REQ-018 A valid/last shift chain SHALL track each issued slot; res_valid only for accepted vectors, res_last only with the result of the act_last vector.
REQ-019 Back-to-back vectors SHALL sustain one result per cycle; gaps in act_valid SHALL produce equal gaps in res_valid.
REQ-020 Accepting act_last moves STREAM -> DRAIN; DRAIN holds until res_last is emitted, then DONE.
REQ-021 DONE: done=1 one cycle, busy=0 next cycle; busy=1 in CLEAR through DRAIN.
REQ-022 A one-vector job (act_last on first vector) SHALL be legal and produce one result with res_last=1.
REQ-023 res_y0/res_y1 SHALL hold the last result when res_valid=0.

Reset
REQ-024 rst=0 at any edge (including mid-job) SHALL force IDLE, clear the valid/last chain and skew registers, and drive busy, done, act_ready, res_valid, res_last, res_y0, res_y1, and all sa_* outputs to 0.
REQ-025 No result from a job interrupted by reset SHALL appear after reset deasserts.

Verification
REQ-026 W=[[1,2],[3,4]], one vector a=(1,1) with act_last -> res_valid 5 cycles after acceptance, y0=4, y1=6, res_last=1; done one cycle after the result.
REQ-027 Same W, three back-to-back vectors (1,0),(0,1),(2,3) -> three consecutive results (1,2),(3,4),(11,16); res_last only on third.
REQ-028 W all 16, vector (8,8) -> y0=0, y1=0 (wrap).
REQ-029 Vectors (1,1), gap of 2 cycles, (2,2) last, with W=[[1,2],[3,4]] -> results (4,6) then (8,12) separated by exactly 2 idle cycles.
REQ-030 start pulsed during STREAM -> ignored, W unchanged; rst=0 during DRAIN -> all outputs 0 next cycle, no further res_valid.
REQ-031 Load check: sa_weight_load high exactly 2 cycles after the CLEAR cycle, carrying row-1 weights then row-0 weights.

Source files
------------

// File: rtl/sa2x2_ctrl_if.sv
// Host/array signal bundle for the 2x2 weight-stationary array controller.
// slave is the controller's view; master is the host plus array side.
interface sa2x2_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] w00;
    logic [7:0] w01;
    logic [7:0] w10;
    logic [7:0] w11;
    logic       act_valid;
    logic       act_ready;
    logic [7:0] act_a0;
    logic [7:0] act_a1;
    logic       act_last;
    logic       res_valid;
    logic [7:0] res_y0;
    logic [7:0] res_y1;
    logic       res_last;
    logic       sa_clear;
    logic       sa_weight_load;
    logic [7:0] sa_w_in1;
    logic [7:0] sa_w_in2;
    logic [7:0] sa_act_in1;
    logic [7:0] sa_act_in2;
    logic [7:0] sa_psum_in1;
    logic [7:0] sa_psum_in2;
    logic [7:0] sa_psum_out1;
    logic [7:0] sa_psum_out2;

    modport slave (
        input  start, w00, w01, w10, w11,
        input  act_valid, act_a0, act_a1, act_last,
        input  sa_psum_out1, sa_psum_out2,
        output busy, done, act_ready,
        output res_valid, res_y0, res_y1, res_last,
        output sa_clear, sa_weight_load, sa_w_in1, sa_w_in2,
        output sa_act_in1, sa_act_in2, sa_psum_in1, sa_psum_in2
    );

    modport master (
        output start, w00, w01, w10, w11,
        output act_valid, act_a0, act_a1, act_last,
        output sa_psum_out1, sa_psum_out2,
        input  busy, done, act_ready,
        input  res_valid, res_y0, res_y1, res_last,
        input  sa_clear, sa_weight_load, sa_w_in1, sa_w_in2,
        input  sa_act_in1, sa_act_in2, sa_psum_in1, sa_psum_in2
    );
endinterface

// File: rtl/sa2x2_ctrl.sv
// Job controller for a 2x2 weight-stationary systolic array: loads weights,
// skews activations in, deskews partial sums out with a fixed 5-cycle latency.
module sa2x2_ctrl (
    input logic        clk,
    input logic        rst,
    sa2x2_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StClear, StLoad0, StLoad1, StStream, StDrain, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] w00_q, w01_q, w10_q, w11_q;

    // One entry per issued slot: valid/last travel alongside the skewed data.
    logic       v1_q, v2_q, v3_q, v4_q;
    logic       l1_q, l2_q, l3_q, l4_q;
    logic [7:0] a0_s1_q, a1_s1_q, a1_s2_q, y0_s4_q;

    logic       res_valid_q, res_last_q;
    logic [7:0] res_y0_q, res_y1_q;

    logic       busy, done, act_ready, sa_clear, sa_weight_load;
    logic [7:0] sa_w_in1, sa_w_in2;
    logic       accept;

    assign accept = act_ready & bus.act_valid;

    always_comb begin
        state_d        = state_q;
        busy           = 1'b0;
        done           = 1'b0;
        act_ready      = 1'b0;
        sa_clear       = 1'b0;
        sa_weight_load = 1'b0;
        sa_w_in1       = 8'd0;
        sa_w_in2       = 8'd0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StClear;
            end
            StClear: begin
                busy     = 1'b1;
                sa_clear = 1'b1;
                state_d  = StLoad0;
            end
            StLoad0: begin
                busy           = 1'b1;
                sa_weight_load = 1'b1;
                sa_w_in1       = w10_q;
                sa_w_in2       = w11_q;
                state_d        = StLoad1;
            end
            StLoad1: begin
                busy           = 1'b1;
                sa_weight_load = 1'b1;
                sa_w_in1       = w00_q;
                sa_w_in2       = w01_q;
                state_d        = StStream;
            end
            StStream: begin
                busy      = 1'b1;
                act_ready = 1'b1;
                if (bus.act_valid && bus.act_last) state_d = StDrain;
            end
            StDrain: begin
                busy = 1'b1;
                if (res_valid_q && res_last_q) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            w00_q       <= 8'd0;
            w01_q       <= 8'd0;
            w10_q       <= 8'd0;
            w11_q       <= 8'd0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            l1_q        <= 1'b0;
            l2_q        <= 1'b0;
            l3_q        <= 1'b0;
            l4_q        <= 1'b0;
            a0_s1_q     <= 8'd0;
            a1_s1_q     <= 8'd0;
            a1_s2_q     <= 8'd0;
            y0_s4_q     <= 8'd0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_y0_q    <= 8'd0;
            res_y1_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.start) begin
                w00_q <= bus.w00;
                w01_q <= bus.w01;
                w10_q <= bus.w10;
                w11_q <= bus.w11;
            end
            // Bubble slots carry zero activations into the array.
            v1_q    <= accept;
            l1_q    <= accept & bus.act_last;
            a0_s1_q <= accept ? bus.act_a0 : 8'd0;
            a1_s1_q <= accept ? bus.act_a1 : 8'd0;
            v2_q    <= v1_q;
            l2_q    <= l1_q;
            a1_s2_q <= a1_s1_q;
            v3_q    <= v2_q;
            l3_q    <= l2_q;
            v4_q    <= v3_q;
            l4_q    <= l3_q;
            if (v3_q) y0_s4_q <= bus.sa_psum_out1;
            res_valid_q <= v4_q;
            res_last_q  <= l4_q;
            if (v4_q) begin
                res_y0_q <= y0_s4_q;
                res_y1_q <= bus.sa_psum_out2;
            end
        end
    end

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.act_ready      = act_ready;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_last       = res_last_q;
    assign bus.res_y0         = res_y0_q;
    assign bus.res_y1         = res_y1_q;
    assign bus.sa_clear       = sa_clear;
    assign bus.sa_weight_load = sa_weight_load;
    assign bus.sa_w_in1       = sa_w_in1;
    assign bus.sa_w_in2       = sa_w_in2;
    assign bus.sa_act_in1     = a0_s1_q;
    assign bus.sa_act_in2     = a1_s2_q;
    assign bus.sa_psum_in1    = 8'd0;
    assign bus.sa_psum_in2    = 8'd0;

endmodule

// File: tb/tb_sa2x2_ctrl.sv
// Bench for sa2x2_ctrl: behavioural 2x2 array attached to the sa_* side,
// results checked against an arithmetic model of y = a*W with fixed latency.
module tb_sa2x2_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sa2x2_ctrl_if bus ();

    sa2x2_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Weight-stationary array: rows fed by act_in1/act_in2, psums flow down columns.
    logic [7:0] wt00 = 0, wt01 = 0, wt10 = 0, wt11 = 0;
    logic [7:0] ar0 = 0, ar1 = 0, p00 = 0, p01 = 0, p10 = 0, p11 = 0;

    always @(posedge clk) begin
        if (bus.sa_clear) begin
            wt00 <= 0; wt01 <= 0; wt10 <= 0; wt11 <= 0;
            ar0 <= 0; ar1 <= 0; p00 <= 0; p01 <= 0; p10 <= 0; p11 <= 0;
        end else begin
            if (bus.sa_weight_load) begin
                wt10 <= wt00;
                wt11 <= wt01;
                wt00 <= bus.sa_w_in1;
                wt01 <= bus.sa_w_in2;
            end
            ar0 <= bus.sa_act_in1;
            ar1 <= bus.sa_act_in2;
            p00 <= bus.sa_psum_in1 + 8'(bus.sa_act_in1 * wt00);
            p01 <= bus.sa_psum_in2 + 8'(ar0 * wt01);
            p10 <= p00 + 8'(bus.sa_act_in2 * wt10);
            p11 <= p01 + 8'(ar1 * wt11);
        end
    end

    assign bus.sa_psum_out1 = p10;
    assign bus.sa_psum_out2 = p11;

    typedef struct {
        int         cyc;
        logic [7:0] y0;
        logic [7:0] y1;
        logic       last;
    } res_t;

    res_t obs_q[$];
    res_t exp_q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] mw00, mw01, mw10, mw11;

    function automatic res_t mk(int c, logic [7:0] y0, logic [7:0] y1, logic l);
        res_t r;
        r.cyc  = c;
        r.y0   = y0;
        r.y1   = y1;
        r.last = l;
        return r;
    endfunction

    function automatic logic [7:0] dot(logic [7:0] a, logic [7:0] b,
                                       logic [7:0] wa, logic [7:0] wb);
        int s;
        s = int'(a) * int'(wa) + int'(b) * int'(wb);
        return 8'(s % 256);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Recorder and reference model: a vector accepted at the next edge yields
    // its result five cycles after that edge.
    always @(negedge clk) begin
        if (bus.res_valid)
            obs_q.push_back(mk(cyc, bus.res_y0, bus.res_y1, bus.res_last));
        if (bus.act_valid && bus.act_ready && rst)
            exp_q.push_back(mk(cyc + 5, dot(bus.act_a0, bus.act_a1, mw00, mw10),
                               dot(bus.act_a0, bus.act_a1, mw01, mw11), bus.act_last));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] a00, input logic [7:0] a01,
                             input logic [7:0] a10, input logic [7:0] a11);
        obs_q.delete();
        exp_q.delete();
        bus.w00 = a00; bus.w01 = a01; bus.w10 = a10; bus.w11 = a11;
        mw00 = a00; mw01 = a01; mw10 = a10; mw11 = a11;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.w00 = 8'($urandom); bus.w01 = 8'($urandom);
        bus.w10 = 8'($urandom); bus.w11 = 8'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the gap.
    task automatic send_vec(input logic [7:0] a0, input logic [7:0] a1,
                            input logic last, input int gap);
        bit ok;
        ok = 1'b0;
        bus.act_valid = 1'b1;
        bus.act_a0    = a0;
        bus.act_a1    = a1;
        bus.act_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.act_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL act_ready_timeout: got ready=0 for 50 cycles, required ready=1");
        end
        tick();
        bus.act_valid = 1'b0;
        bus.act_last  = 1'b0;
        bus.act_a0    = 8'($urandom);
        bus.act_a1    = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_done(output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: got no done in 200 cycles, required a done pulse");
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.act_ready, bus.res_valid, bus.res_last,
             bus.sa_clear, bus.sa_weight_load} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0000000", {bus.busy, bus.done,
                     bus.act_ready, bus.res_valid, bus.res_last, bus.sa_clear,
                     bus.sa_weight_load});
        end
        n_checks++;
        if ({bus.res_y0, bus.res_y1} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_res: got y0=%0d y1=%0d required 0 0", bus.res_y0, bus.res_y1);
        end
        n_checks++;
        if ({bus.sa_w_in1, bus.sa_w_in2, bus.sa_act_in1, bus.sa_act_in2,
             bus.sa_psum_in1, bus.sa_psum_in2} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_sa: got %h required 0", {bus.sa_w_in1, bus.sa_w_in2,
                     bus.sa_act_in1, bus.sa_act_in2, bus.sa_psum_in1, bus.sa_psum_in2});
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_vector();
        int dc;
        start_job(8'd1, 8'd2, 8'd3, 8'd4);
        @(negedge clk);
        n_checks++;
        if ({bus.sa_clear, bus.sa_weight_load, bus.busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL clear_cycle: got clr/load/busy=%b required 101",
                     {bus.sa_clear, bus.sa_weight_load, bus.busy});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.sa_weight_load, bus.sa_w_in1, bus.sa_w_in2} !== {1'b1, 8'd3, 8'd4}) begin
            n_fail++;
            $display("FAIL load_row1: got load=%b w=%0d,%0d required 1 3,4",
                     bus.sa_weight_load, bus.sa_w_in1, bus.sa_w_in2);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.sa_weight_load, bus.sa_w_in1, bus.sa_w_in2} !== {1'b1, 8'd1, 8'd2}) begin
            n_fail++;
            $display("FAIL load_row0: got load=%b w=%0d,%0d required 1 1,2",
                     bus.sa_weight_load, bus.sa_w_in1, bus.sa_w_in2);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.sa_weight_load, bus.act_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stream_entry: got load/ready=%b required 01",
                     {bus.sa_weight_load, bus.act_ready});
        end
        tick();
        send_vec(8'd1, 8'd1, 1'b1, 0);
        wait_done(dc);
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d results required 1", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].y0, obs_q[0].y1, obs_q[0].last} !== {8'd4, 8'd6, 1'b1}) begin
                n_fail++;
                $display("FAIL single_value: got y=%0d,%0d last=%b required 4,6 last=1",
                         obs_q[0].y0, obs_q[0].y1, obs_q[0].last);
            end
            n_checks++;
            if (obs_q[0].cyc != exp_q[0].cyc) begin
                n_fail++;
                $display("FAIL single_latency: got cycle %0d required %0d",
                         obs_q[0].cyc, exp_q[0].cyc);
            end
            n_checks++;
            if (dc != obs_q[0].cyc + 1) begin
                n_fail++;
                $display("FAIL done_timing: got cycle %0d required %0d", dc, obs_q[0].cyc + 1);
            end
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_in_done: got %b required 0", bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL after_done: got done/busy=%b required 00", {bus.done, bus.busy});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int dc;
        logic [7:0] ey0 [3];
        logic [7:0] ey1 [3];
        logic       el [3];
        ey0 = '{8'd1, 8'd3, 8'd11};
        ey1 = '{8'd2, 8'd4, 8'd16};
        el  = '{1'b0, 1'b0, 1'b1};
        start_job(8'd1, 8'd2, 8'd3, 8'd4);
        send_vec(8'd1, 8'd0, 1'b0, 0);
        send_vec(8'd0, 8'd1, 1'b0, 0);
        send_vec(8'd2, 8'd3, 1'b1, 0);
        wait_done(dc);
        n_checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results required 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_q[i].y0, obs_q[i].y1, obs_q[i].last} !== {ey0[i], ey1[i], el[i]} ||
                    obs_q[i].cyc != exp_q[0].cyc + i) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got y=%0d,%0d last=%b cyc=%0d required %0d,%0d last=%b cyc=%0d",
                             i, obs_q[i].y0, obs_q[i].y1, obs_q[i].last, obs_q[i].cyc,
                             ey0[i], ey1[i], el[i], exp_q[0].cyc + i);
                end
            end
        end
        n_checks++;
        if ({bus.res_valid, bus.res_y0, bus.res_y1} !== {1'b0, 8'd11, 8'd16}) begin
            n_fail++;
            $display("FAIL res_hold: got valid=%b y=%0d,%0d required 0 11,16",
                     bus.res_valid, bus.res_y0, bus.res_y1);
        end
        tick();
    endtask

    task automatic test_wrap();
        int dc;
        start_job(8'd16, 8'd16, 8'd16, 8'd16);
        send_vec(8'd8, 8'd8, 1'b1, 0);
        wait_done(dc);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d results required 1", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].y0, obs_q[0].y1, obs_q[0].last} !== {8'd0, 8'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL wrap_value: got y=%0d,%0d last=%b required 0,0 last=1",
                         obs_q[0].y0, obs_q[0].y1, obs_q[0].last);
            end
        end
        tick();
    endtask

    task automatic test_gap();
        int dc;
        start_job(8'd1, 8'd2, 8'd3, 8'd4);
        send_vec(8'd1, 8'd1, 1'b0, 2);
        send_vec(8'd2, 8'd2, 1'b1, 0);
        wait_done(dc);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL gap_count: got %0d results required 2", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].y0, obs_q[0].y1, obs_q[1].y0, obs_q[1].y1, obs_q[1].last} !==
                {8'd4, 8'd6, 8'd8, 8'd12, 1'b1}) begin
                n_fail++;
                $display("FAIL gap_values: got %0d,%0d then %0d,%0d last=%b required 4,6 then 8,12 last=1",
                         obs_q[0].y0, obs_q[0].y1, obs_q[1].y0, obs_q[1].y1, obs_q[1].last);
            end
            n_checks++;
            if (obs_q[1].cyc - obs_q[0].cyc != 3) begin
                n_fail++;
                $display("FAIL gap_spacing: got %0d cycles apart required 3",
                         obs_q[1].cyc - obs_q[0].cyc);
            end
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int dc;
        start_job(8'd1, 8'd2, 8'd3, 8'd4);
        send_vec(8'd1, 8'd1, 1'b0, 0);
        bus.w00 = 8'd9; bus.w01 = 8'd9; bus.w10 = 8'd9; bus.w11 = 8'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.act_ready, bus.sa_clear} !== 3'b110) begin
            n_fail++;
            $display("FAIL start_in_stream: got busy/ready/clear=%b required 110",
                     {bus.busy, bus.act_ready, bus.sa_clear});
        end
        tick();
        send_vec(8'd1, 8'd0, 1'b1, 0);
        wait_done(dc);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL ign_count: got %0d results required 2", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].y0, obs_q[0].y1, obs_q[1].y0, obs_q[1].y1} !==
                {8'd4, 8'd6, 8'd1, 8'd2}) begin
                n_fail++;
                $display("FAIL ign_weights: got %0d,%0d then %0d,%0d required 4,6 then 1,2",
                         obs_q[0].y0, obs_q[0].y1, obs_q[1].y0, obs_q[1].y1);
            end
        end
        tick();
    endtask

    task automatic test_reset_drain();
        int late;
        start_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        send_vec(8'd5, 8'd7, 1'b0, 0);
        send_vec(8'd3, 8'd2, 1'b1, 0);
        n_checks++;
        if ({bus.busy, bus.act_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL drain_state: got busy/ready=%b required 10", {bus.busy, bus.act_ready});
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.act_ready, bus.res_valid, bus.res_last, bus.sa_clear,
             bus.sa_weight_load, bus.res_y0, bus.res_y1, bus.sa_act_in1, bus.sa_act_in2,
             bus.sa_w_in1, bus.sa_w_in2} !== 55'd0) begin
            n_fail++;
            $display("FAIL drain_reset_outputs: got busy=%b valid=%b y=%0d,%0d act=%0d,%0d required all 0",
                     bus.busy, bus.res_valid, bus.res_y0, bus.res_y1,
                     bus.sa_act_in1, bus.sa_act_in2);
        end
        late = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.res_valid || bus.done || bus.busy) late++;
        end
        n_checks++;
        if (late != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_no_result: got %0d active cycles, %0d results required 0, 0",
                     late, obs_q.size());
        end
        tick();
    endtask

    task automatic test_random();
        int dc;
        int nv;
        for (int job = 0; job < 8; job++) begin
            start_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            nv = int'($urandom_range(1, 6));
            for (int v = 0; v < nv; v++)
                send_vec(8'($urandom), 8'($urandom), v == nv - 1, int'($urandom_range(0, 3)));
            wait_done(dc);
            n_checks++;
            if (obs_q.size() != nv || exp_q.size() != nv) begin
                n_fail++;
                $display("FAIL rand_count job%0d: got %0d results required %0d",
                         job, obs_q.size(), nv);
            end else begin
                for (int i = 0; i < nv; i++) begin
                    n_checks++;
                    if (obs_q[i] != exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand_result job%0d/%0d: got y=%0d,%0d last=%b cyc=%0d required y=%0d,%0d last=%b cyc=%0d",
                                 job, i, obs_q[i].y0, obs_q[i].y1, obs_q[i].last,
                                 obs_q[i].cyc, exp_q[i].y0, exp_q[i].y1, exp_q[i].last,
                                 exp_q[i].cyc);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.w00       = 8'd0;
        bus.w01       = 8'd0;
        bus.w10       = 8'd0;
        bus.w11       = 8'd0;
        bus.act_valid = 1'b0;
        bus.act_a0    = 8'd0;
        bus.act_a1    = 8'd0;
        bus.act_last  = 1'b0;
        mw00 = 0; mw01 = 0; mw10 = 0; mw11 = 0;
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_wrap();
        test_gap();
        test_start_ignored();
        test_reset_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
